// File: rtl/conv3x3_mac_seq.sv
// rtl/conv3x3_mac_seq.sv - sequential 3x3 convolution MAC engine with shift normalisation and clip encoding
// Optional: CONV_ROUND_EN adds round-half-up before the normalisation shift.
module conv3x3_mac_seq #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 4,
  parameter int SHIFT  = 0,
  parameter int WIDTH  = 9
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [9*PIX_W-1:0]   win_in,
  input  logic [9*COEF_W-1:0]  kern_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     data_out,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int ACC_W = PIX_W + COEF_W + 4;
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (WIDTH-1)) - 1);
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'((1 << SHIFT) >> 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                    state_q, state_d;
  logic [9*PIX_W-1:0]        win_q, win_d;
  logic [9*COEF_W-1:0]       kern_q, kern_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [3:0]                tap_q, tap_d;
  logic [WIDTH-1:0]          data_q, data_d;

  logic [PIX_W-1:0]          pix;
  logic [COEF_W-1:0]         coef;
  logic signed [ACC_W-1:0]   pix_x, coef_x, prod, mac_sum, rounded, shifted;
  logic [WIDTH-1:0]          enc;

  assign pix    = win_q[tap_q*PIX_W +: PIX_W];
  assign coef   = kern_q[tap_q*COEF_W +: COEF_W];
  assign pix_x  = {{(ACC_W-PIX_W){1'b0}}, pix};
  assign coef_x = {{(ACC_W-COEF_W){coef[COEF_W-1]}}, coef};
  assign prod    = pix_x * coef_x;
  assign mac_sum = acc_q + prod;

`ifdef CONV_ROUND_EN
  assign rounded = mac_sum + RND;
`else
  assign rounded = mac_sum;
`endif

  assign shifted = rounded >>> SHIFT;

  // Negative results saturate to all ones so the clipper sees 2'b11 in the top bits.
  always_comb begin
    if (shifted[ACC_W-1])
      enc = {WIDTH{1'b1}};
    else if (shifted > MAXV)
      enc = {1'b1, {(WIDTH-1){1'b0}}};
    else
      enc = shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)        state_d = S_MAC;
      S_MAC:   if (tap_q == 4'd8)   state_d = S_OUT;
      S_OUT:   if (out_ready)       state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_OUT);
  end

  always_comb begin
    win_d  = win_q;
    kern_d = kern_q;
    acc_d  = acc_q;
    tap_d  = tap_q;
    data_d = data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          win_d  = win_in;
          kern_d = kern_in;
          acc_d  = '0;
          tap_d  = '0;
        end
      end
      S_MAC: begin
        acc_d = mac_sum;
        if (tap_q == 4'd8) begin
          tap_d  = '0;
          data_d = enc;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      win_q  <= '0;
      kern_q <= '0;
      acc_q  <= '0;
      tap_q  <= '0;
      data_q <= '0;
    end else begin
      win_q  <= win_d;
      kern_q <= kern_d;
      acc_q  <= acc_d;
      tap_q  <= tap_d;
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_conv3x3_mac_seq.sv
// tb/tb_conv3x3_mac_seq.sv - randomized self-checking bench for conv3x3_mac_seq
// Three instances (SHIFT 0, 1, 3) run in lockstep on shared inputs.
module tb_conv3x3_mac_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [71:0] win = '0;
  logic [35:0] kern = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        rdy0, rdy1, rdy3, ov0, ov1, ov3;
  logic [8:0]  d0, d1, d3;

  int n_checks = 0;
  int n_errors = 0;

`ifdef CONV_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  always #5 clk = ~clk;

  conv3x3_mac_seq #(.SHIFT(0)) u_s0 (.clk_in(clk), .rst_in(rst), .win_in(win), .kern_in(kern),
    .in_valid(in_valid), .in_ready(rdy0), .data_out(d0), .out_valid(ov0), .out_ready(out_ready));
  conv3x3_mac_seq #(.SHIFT(1)) u_s1 (.clk_in(clk), .rst_in(rst), .win_in(win), .kern_in(kern),
    .in_valid(in_valid), .in_ready(rdy1), .data_out(d1), .out_valid(ov1), .out_ready(out_ready));
  conv3x3_mac_seq #(.SHIFT(3)) u_s3 (.clk_in(clk), .rst_in(rst), .win_in(win), .kern_in(kern),
    .in_valid(in_valid), .in_ready(rdy3), .data_out(d3), .out_valid(ov3), .out_ready(out_ready));

  // Reference: integer dot product, optional rounding, floor shift, then clip encoding.
  function automatic int model(input logic [71:0] w, input logic [35:0] k, input int sh);
    int s;
    s = 0;
    for (int i = 0; i < 9; i++)
      s += int'(w[i*8 +: 8]) * int'($signed(k[i*4 +: 4]));
    if (ROUND && sh > 0)
      s += 1 << (sh - 1);
    s = s >>> sh;
    if (s < 0)   return 511;
    if (s > 255) return 256;
    return s;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic txn(input logic [71:0] w, input logic [35:0] k, input int hold);
    int g, lat, e0, e1, e3;
    e0 = model(w, k, 0);
    e1 = model(w, k, 1);
    e3 = model(w, k, 3);
    g = 0;
    while (!rdy0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_idle", int'(rdy0), 1);
    win = w;
    kern = k;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!ov0 && lat < 30) begin
      chk("busy_in_ready", int'(rdy0), 0);
      win = {$urandom, $urandom, $urandom};
      kern = {$urandom, $urandom};
      out_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("latency", lat, 10);
    chk("lockstep_valid", int'({ov1, ov3}), 3);
    chk("data_s0", int'(d0), e0);
    chk("data_s1", int'(d1), e1);
    chk("data_s3", int'(d3), e3);
    for (int i = 0; i < hold; i++) begin
      win = {$urandom, $urandom, $urandom};
      @(negedge clk);
      chk("hold_valid", int'(ov0), 1);
      chk("hold_in_ready", int'(rdy0), 0);
      chk("hold_data", int'(d0), e0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", int'(ov0), 0);
    chk("release_in_ready", int'(rdy0), 1);
  endtask

  function automatic logic [35:0] kern_all(input logic [3:0] c);
    logic [35:0] r;
    for (int i = 0; i < 9; i++) r[i*4 +: 4] = c;
    return r;
  endfunction

  function automatic logic [71:0] win_all(input logic [7:0] p);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = p;
    return r;
  endfunction

  initial begin
    logic [71:0] w;
    logic [35:0] k;

    @(negedge clk);
    @(negedge clk);
    chk("reset_in_ready", int'(rdy0), 1);
    chk("reset_out_valid", int'(ov0), 0);
    chk("reset_data", int'(d0), 0);
    rst = 1'b0;
    @(negedge clk);

    // Model pinned by hand-computed values.
    w = '0; w[4*8 +: 8] = 8'd200;
    k = '0; k[4*4 +: 4] = 4'd1;
    chk("model_identity", model(w, k, 0), 200);
    chk("model_overflow", model(win_all(8'd255), kern_all(4'd1), 3), 256);
    chk("model_ones_s1", model(win_all(8'd1), kern_all(4'd1), 1), ROUND ? 5 : 4);

    txn(w, k, 0);
    chk("dut_identity", int'(d0), 200);

    txn(win_all(8'd255), kern_all(4'd1), 5);
    chk("dut_overflow_s3", int'(d3), 256);

    w = win_all(8'd255); w[4*8 +: 8] = 8'd0;
    k = '0;
    k[1*4 +: 4] = 4'hF; k[3*4 +: 4] = 4'hF; k[5*4 +: 4] = 4'hF; k[7*4 +: 4] = 4'hF;
    k[4*4 +: 4] = 4'd4;
    txn(w, k, 1);
    chk("dut_negative", int'(d0), 511);

    txn(win_all(8'd1), kern_all(4'd1), 2);
    chk("dut_round_s1", int'(d1), ROUND ? 5 : 4);

    // Asynchronous reset in the middle of accumulation.
    w = win_all(8'd9); k = kern_all(4'd2);
    win = w; kern = k; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(ov0), 0);
    chk("midrst_in_ready", int'(rdy0), 1);
    chk("midrst_data", int'(d0), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_idle_valid", int'(ov0), 0);
    txn(w, k, 0);

    for (int t = 0; t < 12; t++)
      txn({$urandom, $urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 4)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
